// File: rtl/decode_ctrl_pipe.sv
// RV32I decode/control stage with a registered ID/EX bundle, valid/ready handshake,
// load-use bubbling, flush squash, illegal flagging and optional M decode.
module decode_ctrl_pipe #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned ENABLE_M = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              in_ready,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic [XLEN-1:0]   out_imm,
    output logic [4:0]        out_alu_sel,
    output logic              out_b_sel,
    output logic              out_pc_sel,
    output logic              out_brn_enable,
    output logic              out_jump,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic [1:0]        out_wb_sel,
    output logic              out_reg_we,
    output logic              out_ecall,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  bubble_count
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [4:0]      alu_sel;
        logic            b_sel;
        logic            pc_sel;
        logic            brn_enable;
        logic            jump;
        logic            mem_rd;
        logic            mem_wr;
        logic [1:0]      wb_sel;
        logic            reg_we;
        logic            ecall;
        logic            illegal;
    } bundle_t;

    bundle_t     dec;
    bundle_t     q;
    logic        q_valid;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        hazard;
    logic [31:0] imm32;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];

    // Decode the presented instruction into an ID/EX bundle
    always_comb begin
        dec        = '0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        imm32      = '0;
        dec.pc     = in_pc;
        dec.rs1    = in_inst[19:15];
        dec.rs2    = in_inst[24:20];
        dec.funct3 = funct3;
        case (opcode)
            OPC_LUI: begin
                imm32      = {in_inst[31:12], 12'b0};
                dec.rs1    = 5'd0;
                dec.b_sel  = 1'b1;
                dec.wb_sel = WB_ALU;
                dec.reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                imm32      = {in_inst[31:12], 12'b0};
                dec.pc_sel = 1'b1;
                dec.b_sel  = 1'b1;
                dec.wb_sel = WB_ALU;
                dec.reg_we = 1'b1;
            end
            OPC_JAL: begin
                imm32      = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
                dec.pc_sel = 1'b1;
                dec.jump   = 1'b1;
                dec.wb_sel = WB_PC4;
                dec.reg_we = 1'b1;
            end
            OPC_JALR: begin
                imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
                uses_rs1   = 1'b1;
                dec.jump   = 1'b1;
                dec.wb_sel = WB_PC4;
                dec.reg_we = 1'b1;
            end
            OPC_BRANCH: begin
                imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                dec.pc_sel     = 1'b1;
                dec.b_sel      = 1'b1;
                dec.brn_enable = 1'b1;
            end
            OPC_LOAD: begin
                imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
                uses_rs1   = 1'b1;
                dec.b_sel  = 1'b1;
                dec.mem_rd = 1'b1;
                dec.wb_sel = WB_MEM;
                dec.reg_we = 1'b1;
            end
            OPC_STORE: begin
                imm32      = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                dec.b_sel  = 1'b1;
                dec.mem_wr = 1'b1;
            end
            OPC_OPIMM: begin
                imm32       = {{20{in_inst[31]}}, in_inst[31:20]};
                uses_rs1    = 1'b1;
                dec.b_sel   = 1'b1;
                dec.alu_sel = {1'b0, (funct3 == 3'b101) & funct7[5], funct3};
                dec.wb_sel  = WB_ALU;
                dec.reg_we  = 1'b1;
            end
            OPC_OP: begin
                if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                    uses_rs1    = 1'b1;
                    uses_rs2    = 1'b1;
                    dec.alu_sel = {1'b0, funct7[5], funct3};
                    dec.wb_sel  = WB_ALU;
                    dec.reg_we  = 1'b1;
                end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
                    uses_rs1    = 1'b1;
                    uses_rs2    = 1'b1;
                    dec.alu_sel = {1'b1, 1'b0, funct3};
                    dec.wb_sel  = WB_ALU;
                    dec.reg_we  = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                if (in_inst[31:7] == 25'd0) begin
                    dec.ecall = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.imm = XLEN'($signed(imm32));
        dec.rd  = dec.reg_we ? in_inst[11:7] : 5'd0;
    end

    // Load-use: the bundle in EX is a load whose destination this instruction reads
    assign hazard = in_valid && q_valid && q.mem_rd && (q.rd != 5'd0) &&
                    ((uses_rs1 && (dec.rs1 == q.rd)) || (uses_rs2 && (dec.rs2 == q.rd)));

    assign in_ready = flush || ((!q_valid || ex_ready) && !hazard);

    // ID/EX register and bubble counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q            <= '0;
            q_valid      <= 1'b0;
            bubble_count <= '0;
        end else if (flush) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (hazard && ex_ready) begin
            q       <= '0;
            q_valid <= 1'b0;
            if (bubble_count != '1) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end else if (in_valid && in_ready) begin
            q       <= dec;
            q_valid <= 1'b1;
        end else if (q_valid && !ex_ready) begin
            q       <= q;
            q_valid <= q_valid;
        end else begin
            q       <= '0;
            q_valid <= 1'b0;
        end
    end

    assign out_valid      = q_valid;
    assign out_pc         = q.pc;
    assign out_rd         = q.rd;
    assign out_rs1        = q.rs1;
    assign out_rs2        = q.rs2;
    assign out_funct3     = q.funct3;
    assign out_imm        = q.imm;
    assign out_alu_sel    = q.alu_sel;
    assign out_b_sel      = q.b_sel;
    assign out_pc_sel     = q.pc_sel;
    assign out_brn_enable = q.brn_enable;
    assign out_jump       = q.jump;
    assign out_mem_rd     = q.mem_rd;
    assign out_mem_wr     = q.mem_wr;
    assign out_wb_sel     = q.wb_sel;
    assign out_reg_we     = q.reg_we;
    assign out_ecall      = q.ecall;
    assign out_illegal    = q.illegal;

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
Registered RV32I decode/control stage for the five-stage core. It replaces the purely combinational decoder with an ID/EX pipeline register carrying a valid/ready handshake. It adds load-use hazard bubbling, branch-flush squash, illegal-opcode flagging, optional M-extension decode and a saturating bubble counter. It sits between the fetch/IF-ID register and the execute stage.

Parameters:
XLEN, 32, datapath width; imm sign-extended to XLEN; legal values >= 32
PC_W, 32, program-counter width
ENABLE_M, 0, 1 = decode OP with funct7=0000001 as MUL/DIV; 0 = flag as illegal
CNT_W, 16, width of the bubble counter

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  fetch presents an instruction
in_inst  in  32  instruction word
in_pc  in  PC_W  PC of in_inst
in_ready  out  1  stage accepts in_inst this cycle
ex_ready  in  1  execute accepts the registered bundle this cycle
flush  in  1  taken branch/jump resolved; squash the wrong path
out_valid  out  1  bundle valid
out_pc  out  PC_W  registered PC
out_rd, out_rs1, out_rs2  out  5 each  register indices; out_rd forced 0 when out_reg_we=0
out_funct3  out  3  registered funct3
out_imm  out  XLEN  sign-extended immediate
out_alu_sel  out  5  {m_op, funct7[5] qualifier, funct3}
out_b_sel  out  1  0 = rs2, 1 = imm
out_pc_sel  out  1  0 = rs1, 1 = pc as ALU operand A
out_brn_enable  out  1  conditional branch
out_jump  out  1  JAL/JALR
out_mem_rd, out_mem_wr  out  1 each  load / store
out_wb_sel  out  2  0 = mem, 1 = alu, 2 = pc+4
out_reg_we  out  1  regfile write
out_ecall, out_illegal  out  1 each  SYSTEM / unknown encoding
bubble_count  out  CNT_W  saturating count of inserted load-use bubbles

Behaviour:
- Reset (reset=0, async): every output register clears to 0, including bubble_count. in_ready is combinational and reads 1 while out_valid=0.
- Latency: 1 cycle. An accepted instruction (in_valid && in_ready) appears on the outputs on the next edge.
- Combinational hazard = in_valid && out_valid && out_mem_rd && out_rd!=0 && ((uses_rs1 && rs1==out_rd) || (uses_rs2 && rs2==out_rd)).
  - uses_rs1: all opcodes except LUI, AUIPC, JAL, SYSTEM, illegal.
  - uses_rs2: BRANCH, STORE, OP.
- in_ready = flush || ((!out_valid || ex_ready) && !hazard).
- Register update, in priority order:
  1. flush=1: out_valid<=0. Any input presented that cycle is consumed and dropped. No bubble is counted.
  2. Hazard with ex_ready=1: out_valid<=0 (bubble), input held. bubble_count += 1, saturating at all-ones.
  3. Accept: load the decoded bundle, out_valid<=1.
  4. out_valid && !ex_ready: hold all outputs unchanged (no change while stalled).
  5. Otherwise: out_valid<=0.
- When out_valid=0, all control outputs (reg_we, mem_rd/wr, brn_enable, jump, ecall, illegal) are registered as 0.
- Opcode decode:
  - LUI 0110111: imm=U, pc_sel=0 with rs1 forced to x0, b_sel=1, alu add, wb=1, we=1.
  - AUIPC 0010111: imm=U, pc_sel=1, b_sel=1, add, wb=1, we=1.
  - JAL 1101111: imm=J (bit0=0, no extra shift), pc_sel=1, jump=1, wb=2, we=1.
  - JALR 1100111: imm=I, pc_sel=0, jump=1, wb=2, we=1.
  - BRANCH 1100011: imm=B, pc_sel=1, b_sel=1, brn_enable=1, we=0.
  - LOAD 0000011: imm=I, b_sel=1, mem_rd=1, wb=0, we=1.
  - STORE 0100011: imm=S, b_sel=1, mem_wr=1, we=0.
  - OP-IMM 0010011: imm=I, b_sel=1, alu_sel[3]=funct7[5] only for funct3=101.
  - OP 0110011: b_sel=0, alu_sel[3]=funct7[5]. funct7=0000001 with ENABLE_M=1 gives alu_sel[4]=1. Any other funct7 outside {0000000, 0100000} is illegal.
  - SYSTEM 1110011 with inst[31:7]=0: ecall=1, we=0.
  - Anything else: illegal=1, all writes 0.
- Immediates are sign-extended from inst[31] to XLEN.
- Reset asserted mid-stall: the bundle is discarded; no partial state survives.

Test Plan:
- Reset then in_inst=0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle out_valid=1, out_rd=1, out_imm=5, b_sel=1, wb_sel=1, reg_we=1.
- 0xFFF00093 -> out_imm=0xFFFFFFFF. With XLEN=64, out_imm=0xFFFF_FFFF_FFFF_FFFF.
- 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1) -> one cycle with in_ready=0 and a bubble (out_valid=0), bubble_count=1, then add issues. Repeat with add rd=x0 source -> no bubble.
- Hold ex_ready=0 for 3 cycles with the add bundle valid -> outputs unchanged, in_ready=0. Release -> next instruction accepted.
- flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, input dropped, bubble_count unchanged.
- 0x022081B3 (mul x3,x1,x2) -> ENABLE_M=1: alu_sel=5'b10000, illegal=0. ENABLE_M=0: illegal=1, reg_we=0. 0x0000007F -> illegal=1.
